// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: memory-op and branch codes, ALU flag
// positions and the access state machine states.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_e;

    localparam logic [3:0] BR_NONE   = 4'd0;
    localparam logic [3:0] BR_ALWAYS = 4'd1;
    localparam logic [3:0] BR_EQ     = 4'd2;
    localparam logic [3:0] BR_NE     = 4'd3;
    localparam logic [3:0] BR_LT     = 4'd4;
    localparam logic [3:0] BR_GE     = 4'd5;

    // alu_cond is packed {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_branch_eval.sv
// Combinational branch resolution from branch code and ALU flags; kept
// standalone so hazard/forwarding logic can reuse the same decision.
module mem_stage_branch_eval
    import mem_stage_pkg::*;
(
    input  logic [3:0] br,
    input  logic [3:0] alu_cond,
    output logic       taken
);

    logic lt;
    logic unused_carry;

    assign lt           = alu_cond[FLAG_N] ^ alu_cond[FLAG_V];
    assign unused_carry = alu_cond[FLAG_C];

    always_comb begin
        case (br)
            BR_ALWAYS: taken = 1'b1;
            BR_EQ:     taken = alu_cond[FLAG_Z];
            BR_NE:     taken = !alu_cond[FLAG_Z];
            BR_LT:     taken = lt;
            BR_GE:     taken = !lt;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: resolves branches, runs the data-memory handshake with
// timeout, and registers the MEM/WB entry.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        br,
    input  logic [3:0]        alu_cond,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] adder,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        mem_op,
    input  logic [RD_W-1:0]   rd,
    output logic              stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_cap_q, rd_cap_d;
    logic              branch_taken_q, branch_taken_d;
    logic [DATA_W-1:0] branch_target_q, branch_target_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              mem_err_q, mem_err_d;

    logic taken;
    logic aligned;
    logic timeout_hit;
    logic unused_imm;

    mem_stage_branch_eval u_branch_eval (
        .br       (br),
        .alu_cond (alu_cond),
        .taken    (taken)
    );

    assign unused_imm  = ^immediate;
    assign aligned     = (alu[1:0] == 2'b00);
    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Drops in the completing WAIT cycle so upstream advances on that same edge.
    assign stall = ((state_q == ST_IDLE) && in_valid && is_mem_op(mem_op) && aligned) ||
                   ((state_q == ST_WAIT) && !dmem.ack && !timeout_hit);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rd_cap_d        = rd_cap_q;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;
        wb_valid_d      = 1'b0;
        wb_we_d         = 1'b0;
        wb_data_d       = wb_data_q;
        wb_rd_d         = wb_rd_q;
        mem_err_d       = mem_err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    branch_taken_d = taken;
                    if (taken) begin
                        branch_target_d = adder;
                    end
                    if (is_mem_op(mem_op) && aligned) begin
                        req_d    = 1'b1;
                        we_d     = (mem_op == MEM_STORE);
                        addr_d   = alu;
                        wdata_d  = store_data;
                        rd_cap_d = rd;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end else if (is_mem_op(mem_op)) begin
                        mem_err_d  = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu;
                        wb_rd_d    = rd;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (br == BR_NONE) && (rd != '0);
                        wb_data_d  = alu;
                        wb_rd_d    = rd;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (dmem.ack) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_cap_q;
                    if (!we_q) begin
                        wb_data_d = dmem.rdata;
                        wb_we_d   = (rd_cap_q != '0);
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    mem_err_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_cap_q;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_cap_q        <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            wb_valid_q      <= 1'b0;
            wb_we_q         <= 1'b0;
            wb_data_q       <= '0;
            wb_rd_q         <= '0;
            mem_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rd_cap_q        <= rd_cap_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            wb_valid_q      <= wb_valid_d;
            wb_we_q         <= wb_we_d;
            wb_data_q       <= wb_data_d;
            wb_rd_q         <= wb_rd_d;
            mem_err_q       <= mem_err_d;
        end
    end

    assign dmem.req      = req_q;
    assign dmem.we       = we_q;
    assign dmem.addr     = addr_q;
    assign dmem.wdata    = wdata_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign wb_valid      = wb_valid_q;
    assign wb_we         = wb_we_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign mem_err       = mem_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline register.
- Takes the registered EX results (branch code, ALU flags, ALU result, branch adder, immediate, rd) plus a memory-op field.
- Resolves branches, performs data-memory load/store over a req/ack handshake, and produces the registered MEM/WB outputs.
- Stalls upstream while a memory access is outstanding.

Parameters:
DATA_W, 32, datapath/address width
RD_W, 6, destination register index width
TIMEOUT, 16, max cycles waiting for dmem_ack before abort (≥1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  EX/MEM entry valid
br  in  4  branch code (0 none, 1 always, 2 EQ, 3 NE, 4 LT, 5 GE, others = none)
alu_cond  in  4  flags {N,Z,C,V}
alu  in  DATA_W  ALU result; memory address for load/store
adder  in  DATA_W  branch target
immediate  in  DATA_W  unused for data; reserved
store_data  in  DATA_W  store write data
mem_op  in  2  0 none, 1 load, 2 store, 3 treated as none
rd  in  RD_W  destination register
stall  out  1  upstream hold request (combinational)
branch_taken  out  1  one-cycle pulse, registered
branch_target  out  DATA_W  registered, valid with branch_taken
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = store
dmem_addr  out  DATA_W  word-aligned address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid with dmem_ack
dmem_ack  in  1  memory completion, sampled only while dmem_req=1
wb_valid  out  1  one-cycle pulse, MEM/WB entry valid
wb_we  out  1  register write enable
wb_data  out  DATA_W  writeback value
wb_rd  out  RD_W  writeback register
mem_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, mem_err cleared.
- States:
  - IDLE: accepting.
  - WAIT: access outstanding. Operands captured; live inputs ignored.
- IDLE, in_valid, mem_op none → next edge:
  - wb_valid=1, wb_data=alu, wb_rd=rd.
  - wb_we = (br==0 && rd!=0).
  - Latency 1.
- Branch (IDLE, in_valid):
  - Taken condition by code: always; EQ: Z; NE: !Z; LT: N^V; GE: !(N^V).
  - Taken → next edge branch_taken=1, branch_target=adder for exactly one cycle.
  - Branches never write back; wb_valid still pulses with wb_we=0.
- Load/store (IDLE, in_valid, alu[1:0]==0):
  - Capture alu, store_data, rd, mem_op.
  - Next edge: dmem_req=1, dmem_we=(store), dmem_addr, dmem_wdata. Go to WAIT.
  - In WAIT, dmem_req/addr/wdata/we are held stable until ack.
- Misaligned load/store (alu[1:0]!=0):
  - No request; next edge mem_err=1, wb_valid=1, wb_we=0.
  - No stall.
- WAIT with dmem_ack=1 → next edge:
  - dmem_req=0, wb_valid=1, wb_rd=captured rd.
  - Load: wb_data=dmem_rdata, wb_we=(rd!=0).
  - Store: wb_we=0.
  - Return to IDLE.
- Timeout:
  - Counter increments each WAIT cycle without ack.
  - At count TIMEOUT-1 with no ack: next edge drop dmem_req, mem_err=1, wb_valid=1, wb_we=0, return to IDLE.
  - Ack on that same cycle wins over timeout.
- stall = (IDLE && in_valid && mem_op∈{1,2} && aligned) || (WAIT && !dmem_ack && !timeout_hit).
  - Stall drops in the completing cycle so upstream advances on that edge; the held instruction is never re-executed.
- dmem_ack while dmem_req=0: ignored.
- rst during WAIT: request dropped immediately at that edge; no wb_valid.
- mem_err stays set until rst.

Decomposition:
- Shared package: mem_op encodings, branch code encodings, flag bit indices, state enum.
- Sub-module: branch_eval (combinational br × alu_cond → taken), reused by a future forwarding/hazard unit.

Test Plan:
- ALU op alu=0x1234, rd=5, br=0 → 1 cycle later wb_valid=1, wb_data=0x1234, wb_rd=5, wb_we=1, stall never high.
- br=2, alu_cond Z=1, adder=0x80 → branch_taken pulse 1 cycle, branch_target=0x80, wb_we=0. Same stimulus with Z=0 → no pulse.
- Load addr 0x100, rd=7, ack after 3 cycles with rdata=0xDEADBEEF:
  - stall high until the ack cycle.
  - addr stable throughout.
  - wb_data=0xDEADBEEF, wb_we=1, exactly one wb_valid.
- Store addr 0x40, data 0xA5A5 → dmem_we=1, dmem_wdata=0xA5A5; after ack, wb_valid=1 with wb_we=0.
- Load with ack never returned, TIMEOUT=16 → dmem_req drops after 16 WAIT cycles, mem_err=1, stall released.
- Load to alu=0x102 → no dmem_req, mem_err=1 next cycle. rst asserted mid-WAIT → all outputs 0 the next cycle.
